// File: rtl/hack_mem_pkg.sv
// Shared definitions for the Hack memory map: the region type, the default
// sizing constants and the address decode helper used by the top level.
package hack_mem_pkg;

    typedef enum logic [1:0] {
        REGION_RAM    = 2'd0,
        REGION_SCREEN = 2'd1,
        REGION_KBD    = 2'd2,
        REGION_NONE   = 2'd3
    } region_t;

    localparam int DEFAULT_DATA_W       = 16;
    localparam int DEFAULT_ADDR_W       = 15;
    localparam int DEFAULT_RAM_WORDS    = 16384;
    localparam int DEFAULT_SCREEN_WORDS = 8192;
    localparam int DEFAULT_KBD_DEPTH    = 4;
    localparam int KEY_W                = 8;

    // Classify an address. The screen window runs up to and including the
    // word just below the keyboard register.
    function automatic region_t decode_region(
        input longint unsigned addr,
        input longint unsigned screen_base,
        input longint unsigned kbd_addr
    );
        region_t r;
        if (addr < screen_base) begin
            r = REGION_RAM;
        end else if (addr < kbd_addr) begin
            r = REGION_SCREEN;
        end else if (addr == kbd_addr) begin
            r = REGION_KBD;
        end else begin
            r = REGION_NONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/hack_sync_ram.sv
// Single-clock data RAM: one write port, one synchronous read port with a
// one-cycle read latency (read-before-write on a same-address collision).
// Contents are intentionally not reset.
module hack_sync_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16384
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         q
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Commit the write and register the read word on the same edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        q <= mem[raddr];
    end

endmodule

// File: rtl/hack_memory_map.sv
// Hack computer memory map: data RAM, memory-mapped screen window and a
// keyboard register. Every region reads back with one cycle of latency.
// Optional feature: define HACK_KBD_FIFO_EN to put a small key-event FIFO
// with a sticky overflow flag behind the keyboard register; without it the
// register simply shows the live key code.
module hack_memory_map
    import hack_mem_pkg::*;
#(
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int ADDR_W       = DEFAULT_ADDR_W,
    parameter int RAM_WORDS    = DEFAULT_RAM_WORDS,
    parameter int SCREEN_WORDS = DEFAULT_SCREEN_WORDS,
    parameter int KBD_DEPTH    = DEFAULT_KBD_DEPTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [ADDR_W-1:0]               address,
    input  logic [DATA_W-1:0]               in,
    input  logic                            load,
    output logic [DATA_W-1:0]               out,
    input  logic [7:0]                      keyboard,
    input  logic                            kbd_strobe,
    output logic [$clog2(SCREEN_WORDS)-1:0] screen_address,
    output logic [DATA_W-1:0]               screen_data,
    output logic                            screen_we,
    output logic [$clog2(SCREEN_WORDS)-1:0] screen_raddr,
    input  logic [DATA_W-1:0]               screen_rdata
);

    localparam int SCREEN_BASE = RAM_WORDS;
    localparam int KBD_ADDR    = RAM_WORDS + SCREEN_WORDS;
    localparam int RAM_AW      = $clog2(RAM_WORDS);
    localparam int SCR_AW      = $clog2(SCREEN_WORDS);

    // Reject maps that cannot be built: the keyboard word must be
    // addressable, sizes must be powers of two and the keyboard word
    // needs room for the key code plus the overflow flag.
    if (64'(KBD_ADDR) >= (64'(1) << ADDR_W)) begin : g_bad_map
        $error("hack_memory_map: KBD_ADDR does not fit in ADDR_W bits");
    end
    if ((RAM_WORDS & (RAM_WORDS - 1)) != 0 ||
        (SCREEN_WORDS & (SCREEN_WORDS - 1)) != 0) begin : g_bad_size
        $error("hack_memory_map: RAM_WORDS and SCREEN_WORDS must be powers of two");
    end
    if (KBD_DEPTH < 2 || (KBD_DEPTH & (KBD_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("hack_memory_map: KBD_DEPTH must be a power of two, at least 2");
    end
    if (DATA_W <= KEY_W) begin : g_bad_width
        $error("hack_memory_map: DATA_W must exceed the key code width");
    end

    region_t           region;
    region_t           region_q;
    logic [ADDR_W-1:0] screen_off;
    logic              ram_we;
    logic [DATA_W-1:0] ram_q;
    logic [DATA_W-1:0] kbd_word;
    logic              screen_wr;
    logic              unused_bits;

    // Decode the current CPU address into a region.
    always_comb begin
        region = decode_region(64'(address), 64'(SCREEN_BASE), 64'(KBD_ADDR));
    end

    assign screen_off   = address - ADDR_W'(SCREEN_BASE);
    assign screen_raddr = screen_off[SCR_AW-1:0];
    assign unused_bits  = ^screen_off[ADDR_W-1:SCR_AW];

    assign ram_we    = load && !reset && (region == REGION_RAM);
    assign screen_wr = load && (region == REGION_SCREEN);

    hack_sync_ram #(
        .WIDTH (DATA_W),
        .DEPTH (RAM_WORDS)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (address[RAM_AW-1:0]),
        .wdata (in),
        .raddr (address[RAM_AW-1:0]),
        .q     (ram_q)
    );

    // Register the screen write port and the region that selects the read mux.
    always_ff @(posedge clk) begin
        if (reset) begin
            screen_we      <= 1'b0;
            screen_address <= '0;
            screen_data    <= '0;
            region_q       <= REGION_NONE;
        end else begin
            screen_we <= screen_wr;
            region_q  <= region;
            if (screen_wr) begin
                screen_address <= screen_off[SCR_AW-1:0];
                screen_data    <= in;
            end
        end
    end

`ifdef HACK_KBD_FIFO_EN
    localparam int PTR_W = $clog2(KBD_DEPTH);

    logic [KEY_W-1:0] fifo_mem [KBD_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             kbd_ovf;
    logic             fifo_empty;
    logic             fifo_full;
    logic             kbd_write;
    logic             push_req;
    logic             push_ok;
    logic             pop;

    // A KBD write pops the head; a push is accepted unless the FIFO is full
    // and nothing leaves in the same cycle.
    always_comb begin
        fifo_empty = (count == '0);
        fifo_full  = (count == (PTR_W + 1)'(KBD_DEPTH));
        kbd_write  = load && !reset && (region == REGION_KBD);
        push_req   = kbd_strobe && !reset;
        pop        = kbd_write && !fifo_empty;
        push_ok    = push_req && (!fifo_full || pop);
    end

    // Store accepted key codes at the tail.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= keyboard;
        end
    end

    // Advance pointers, track occupancy and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            kbd_ovf <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push_ok) begin
                count <= count - 1'b1;
            end
            if (kbd_write) begin
                kbd_ovf <= 1'b0;
            end else if (push_req && !push_ok) begin
                kbd_ovf <= 1'b1;
            end
        end
    end

    // Present the overflow flag in the top bit and the head code at the bottom.
    always_comb begin
        kbd_word           = '0;
        kbd_word[DATA_W-1] = kbd_ovf;
        if (!fifo_empty) begin
            kbd_word[KEY_W-1:0] = fifo_mem[rd_ptr];
        end
    end
`else
    logic [KEY_W-1:0] key_q;
    logic             unused_strobe;

    assign unused_strobe = kbd_strobe;

    // Sample the live key code so it lines up with the registered region.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_q <= '0;
        end else begin
            key_q <= keyboard;
        end
    end

    // Zero-extend the sampled key code into a data word.
    always_comb begin
        kbd_word = DATA_W'(key_q);
    end
`endif

    // Read mux steered by the region registered on the previous edge.
    always_comb begin
        out = '0;
        if (!reset) begin
            case (region_q)
                REGION_RAM:    out = ram_q;
                REGION_SCREEN: out = screen_rdata;
                REGION_KBD:    out = kbd_word;
                default:       out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_hack_memory_map.sv
// Self-checking bench for hack_memory_map with default parameters. Expected
// values come from a behavioural model: associative arrays for RAM and
// screen contents and a queue for the keyboard FIFO. Build with
// HACK_KBD_FIFO_EN defined to exercise the FIFO variant.
module tb_hack_memory_map;

    localparam int          DATA_W      = 16;
    localparam int          ADDR_W      = 15;
    localparam int unsigned SCREEN_BASE = 16384;
    localparam int unsigned KBD_ADDR    = 24576;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wdata;
    logic              load;
    logic [DATA_W-1:0] out;
    logic [7:0]        keyboard;
    logic              kbd_strobe;
    logic [12:0]       screen_address;
    logic [DATA_W-1:0] screen_data;
    logic              screen_we;
    logic [12:0]       screen_raddr;
    logic [DATA_W-1:0] screen_rdata;

    int checks = 0;
    int passes = 0;

    logic [DATA_W-1:0] ram_model [int];
    logic [DATA_W-1:0] scr_model [int];
    logic [7:0]        key_q [$];
    logic              ovf_model = 1'b0;

    logic [DATA_W-1:0] frame_buf [8192];

    hack_memory_map dut (
        .clk            (clk),
        .reset          (reset),
        .address        (address),
        .in             (wdata),
        .load           (load),
        .out            (out),
        .keyboard       (keyboard),
        .kbd_strobe     (kbd_strobe),
        .screen_address (screen_address),
        .screen_data    (screen_data),
        .screen_we      (screen_we),
        .screen_raddr   (screen_raddr),
        .screen_rdata   (screen_rdata)
    );

    always #5 clk = ~clk;

    // External frame buffer: written by the strobe, read one cycle after raddr.
    always @(posedge clk) begin
        if (screen_we) frame_buf[screen_address] <= screen_data;
        screen_rdata <= frame_buf[screen_raddr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] kbd_expect();
        logic [7:0] head;
        head = (key_q.size() > 0) ? key_q[0] : 8'h00;
        return {ovf_model, 7'b0, head};
    endfunction

    task automatic test_reset();
        reset = 1'b1; load = 1'b1; address = 15'd24000; wdata = 16'h5555;
        keyboard = 8'h99; kbd_strobe = 1'b1;
        tick();
        tick();
        checks++; if (out !== 16'h0) $display("[TB] FAIL reset_out: got %h expected 0000", out); else passes++;
        checks++; if (screen_we !== 1'b0) $display("[TB] FAIL reset_we: got %b expected 0", screen_we); else passes++;
        checks++; if (screen_address !== 13'h0) $display("[TB] FAIL reset_saddr: got %h expected 0000", screen_address); else passes++;
        checks++; if (screen_data !== 16'h0) $display("[TB] FAIL reset_sdata: got %h expected 0000", screen_data); else passes++;
        reset = 1'b0; load = 1'b0; kbd_strobe = 1'b0; keyboard = 8'h00; address = 15'd0;
        tick();
    endtask

    task automatic test_ram();
        int a;
        logic [DATA_W-1:0] d;
        address = 15'd5; wdata = 16'h1234; load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        checks++; if (out !== 16'h1234) $display("[TB] FAIL ram_addr5: got %h expected 1234", out); else passes++;
        wdata = 16'hFFFF;
        tick();
        checks++; if (out !== 16'h1234) $display("[TB] FAIL ram_hold: got %h expected 1234", out); else passes++;
        ram_model[5] = 16'h1234;
        for (int i = 0; i < 20; i++) begin
            a = int'($urandom_range(0, 16383));
            d = 16'($urandom);
            address = 15'(a); wdata = d; load = 1'b1;
            tick();
            ram_model[a] = d;
        end
        load = 1'b0;
        foreach (ram_model[k]) begin
            address = 15'(k);
            tick();
            checks++;
            if (out !== ram_model[k]) $display("[TB] FAIL ram_read[%0d]: got %h expected %h", k, out, ram_model[k]);
            else passes++;
        end
    endtask

    task automatic test_screen();
        int o;
        logic [DATA_W-1:0] d;
        address = 15'd24575; wdata = 16'hBEEF; load = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if ({screen_we, screen_address, screen_data} !== {1'b1, 13'h1FFF, 16'hBEEF})
            $display("[TB] FAIL screen_last: got we=%b addr=%h data=%h expected we=1 addr=1fff data=beef",
                     screen_we, screen_address, screen_data);
        else passes++;
        tick();
        checks++; if (screen_we !== 1'b0) $display("[TB] FAIL screen_one_cycle: got %b expected 0", screen_we); else passes++;
        scr_model[8191] = 16'hBEEF;
        for (int i = 0; i < 8; i++) begin
            o = int'($urandom_range(0, 8190));
            d = 16'($urandom);
            address = 15'(int'(SCREEN_BASE) + o); wdata = d; load = 1'b1;
            tick();
            scr_model[o] = d;
            checks++;
            if ({screen_we, screen_address, screen_data} !== {1'b1, 13'(o), d})
                $display("[TB] FAIL screen_write: got we=%b addr=%h data=%h expected we=1 addr=%h data=%h",
                         screen_we, screen_address, screen_data, 13'(o), d);
            else passes++;
        end
        load = 1'b0;
        tick();
        foreach (scr_model[k]) begin
            address = 15'(int'(SCREEN_BASE) + k);
            #1;
            checks++;
            if (screen_raddr !== 13'(k)) $display("[TB] FAIL screen_raddr: got %h expected %h", screen_raddr, 13'(k));
            else passes++;
            tick();
            checks++;
            if (out !== scr_model[k]) $display("[TB] FAIL screen_read[%0d]: got %h expected %h", k, out, scr_model[k]);
            else passes++;
        end
    endtask

    task automatic test_none();
        address = 15'd24577; wdata = 16'hCAFE; load = 1'b1;
        tick();
        load = 1'b0;
        checks++; if (screen_we !== 1'b0) $display("[TB] FAIL none_no_strobe: got %b expected 0", screen_we); else passes++;
        tick();
        checks++; if (out !== 16'h0) $display("[TB] FAIL none_read: got %h expected 0000", out); else passes++;
        for (int i = 0; i < 4; i++) begin
            address = 15'($urandom_range(KBD_ADDR + 1, 32767));
            tick();
            checks++; if (out !== 16'h0) $display("[TB] FAIL none_rand: got %h expected 0000", out); else passes++;
        end
    endtask

`ifndef HACK_KBD_FIFO_EN
    task automatic test_kbd_live();
        logic [7:0] k;
        address = 15'(KBD_ADDR); keyboard = 8'h20; kbd_strobe = 1'b0; load = 1'b0;
        tick();
        checks++; if (out !== 16'h0020) $display("[TB] FAIL kbd_live_20: got %h expected 0020", out); else passes++;
        for (int i = 0; i < 10; i++) begin
            k = 8'($urandom);
            keyboard = k; kbd_strobe = 1'($urandom); load = 1'($urandom); wdata = 16'($urandom);
            tick();
            checks++;
            if (out !== {8'h00, k}) $display("[TB] FAIL kbd_live_rand: got %h expected %h", out, {8'h00, k});
            else passes++;
        end
        keyboard = 8'h00; kbd_strobe = 1'b0; load = 1'b0;
        tick();
    endtask
`else
    task automatic test_kbd_fifo();
        logic st, ld;
        logic [7:0] k;
        logic pop, full;
        address = 15'(KBD_ADDR); load = 1'b0;
        keyboard = 8'h41; kbd_strobe = 1'b1; tick();
        keyboard = 8'h42; tick();
        kbd_strobe = 1'b0; tick();
        checks++; if (out !== 16'h0041) $display("[TB] FAIL fifo_head41: got %h expected 0041", out); else passes++;
        load = 1'b1; tick(); load = 1'b0;
        checks++; if (out !== 16'h0042) $display("[TB] FAIL fifo_head42: got %h expected 0042", out); else passes++;
        load = 1'b1; tick(); load = 1'b0;
        checks++; if (out !== 16'h0000) $display("[TB] FAIL fifo_empty: got %h expected 0000", out); else passes++;
        for (int i = 0; i < 5; i++) begin
            keyboard = 8'(8'h51 + i); kbd_strobe = 1'b1; tick();
        end
        kbd_strobe = 1'b0; tick();
        checks++; if (out !== 16'h8051) $display("[TB] FAIL fifo_ovf: got %h expected 8051", out); else passes++;
        keyboard = 8'h60; kbd_strobe = 1'b1; load = 1'b1; tick();
        kbd_strobe = 1'b0; load = 1'b0;
        checks++; if (out !== 16'h0052) $display("[TB] FAIL fifo_full_pushpop: got %h expected 0052", out); else passes++;
        key_q = '{8'h52, 8'h53, 8'h54, 8'h60};
        ovf_model = 1'b0;
        for (int i = 0; i < 60; i++) begin
            st = 1'($urandom);
            ld = ($urandom_range(0, 2) == 0);
            k  = 8'($urandom);
            keyboard = k; kbd_strobe = st; load = ld; wdata = 16'($urandom);
            tick();
            pop  = ld && (key_q.size() > 0);
            full = (key_q.size() == 4);
            if (ld) ovf_model = 1'b0;
            if (pop) void'(key_q.pop_front());
            if (st) begin
                if (full && !pop) ovf_model = 1'b1;
                else key_q.push_back(k);
            end
            checks++;
            if (out !== kbd_expect()) $display("[TB] FAIL fifo_rand[%0d]: got %h expected %h", i, out, kbd_expect());
            else passes++;
        end
        kbd_strobe = 1'b0; load = 1'b0;
    endtask
`endif

    task automatic test_reset_mid();
        address = 15'd200; wdata = 16'h1111; load = 1'b1;
        tick();
        load = 1'b0;
`ifdef HACK_KBD_FIFO_EN
        keyboard = 8'h33; kbd_strobe = 1'b1; tick();
        kbd_strobe = 1'b0;
`endif
        address = 15'd24000; wdata = 16'h7777; load = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        checks++; if (screen_we !== 1'b0) $display("[TB] FAIL rst_after_write_we: got %b expected 0", screen_we); else passes++;
        tick();
        checks++; if (screen_we !== 1'b0) $display("[TB] FAIL rst_during_write_we: got %b expected 0", screen_we); else passes++;
        checks++; if (out !== 16'h0) $display("[TB] FAIL rst_out: got %h expected 0000", out); else passes++;
        address = 15'd200; wdata = 16'h2222; load = 1'b1;
        tick();
        reset = 1'b0; load = 1'b0; keyboard = 8'h00; address = 15'(KBD_ADDR);
        key_q.delete(); ovf_model = 1'b0;
        tick();
        checks++; if (screen_we !== 1'b0) $display("[TB] FAIL rst_release_we: got %b expected 0", screen_we); else passes++;
        checks++; if (out !== 16'h0) $display("[TB] FAIL rst_kbd_read: got %h expected 0000", out); else passes++;
        address = 15'd200;
        tick();
        checks++; if (out !== 16'h1111) $display("[TB] FAIL rst_ram_kept: got %h expected 1111", out); else passes++;
    endtask

    initial begin
        test_reset();
        test_ram();
        test_screen();
        test_none();
`ifdef HACK_KBD_FIFO_EN
        test_kbd_fifo();
`else
        test_kbd_live();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
